// File: rtl/q_update_engine_if.sv
// RAM-side bus of the Q-update engine: registered-read port plus write port
// of the 64-entry action RAM.
interface q_update_engine_if #(
  parameter int DATA_W = 16
);
  logic              ram_en;
  logic [5:0]        ram_rd_addr;
  logic [DATA_W-1:0] ram_rd_data;
  logic [5:0]        ram_wr_addr;
  logic              ram_write_en;
  logic [DATA_W-1:0] ram_wr_data;

  modport master (
    output ram_en, ram_rd_addr, ram_wr_addr, ram_write_en, ram_wr_data,
    input  ram_rd_data
  );
  modport slave (
    input  ram_en, ram_rd_addr, ram_wr_addr, ram_write_en, ram_wr_data,
    output ram_rd_data
  );
endinterface

// File: rtl/q_update_engine.sv
// Q-learning write-back stage: reads Q(s,a) and Q(s',0..3), writes back
// Q + alpha*(r + gamma*maxQ' - Q). Optional QUPD_TERMINAL_EN adds a terminal input.
module q_update_engine #(
  parameter int DATA_W      = 16,
  parameter int ALPHA_SHIFT = 2,
  parameter int GAMMA_SHIFT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        state_cur,
  input  logic [1:0]        action_cur,
  input  logic [3:0]        state_next,
  input  logic [DATA_W-1:0] reward,
`ifdef QUPD_TERMINAL_EN
  input  logic              terminal,
`endif
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] q_new,
  output logic [1:0]        best_action,
  q_update_engine_if.master ram
);
  localparam int CW = DATA_W + 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    DRAIN = 3'd2,
    CALC  = 3'd3,
    WRITE = 3'd4
  } st_t;

  typedef struct packed {
    logic [3:0]        s;
    logic [1:0]        a;
    logic [3:0]        sn;
    logic [DATA_W-1:0] r;
    logic              term;
  } req_t;

  st_t                      st, st_nx;
  req_t                     req;
  logic [2:0]               cnt;
  logic signed [DATA_W-1:0] q_cur, max_q;
  logic [1:0]               max_idx;
  logic                     cap_nxt;
  logic [1:0]               cap_idx;
  logic signed [CW-1:0]     mx, qx, rx, gq, tgt, td, res;
  logic [DATA_W-1:0]        res_sat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= IDLE;
    else     st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE:    if (start) st_nx = READ;
      READ:    if (cnt == 3'd4) st_nx = DRAIN;
      DRAIN:   st_nx = CALC;
      CALC:    st_nx = WRITE;
      WRITE:   st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  always_comb begin
    busy             = 1'b0;
    done             = 1'b0;
    ram.ram_en       = 1'b0;
    ram.ram_write_en = 1'b0;
    if (st != IDLE) begin
      busy       = 1'b1;
      ram.ram_en = 1'b1;
    end
    if (st == WRITE) begin
      done             = 1'b1;
      ram.ram_write_en = 1'b1;
    end
  end

  // Read data lags its address by one cycle, so Q(s',k) arrives while cnt=k+2;
  // the last next-state entry lands during DRAIN.
  always_comb begin
    cap_nxt = (st == DRAIN) || (st == READ && cnt >= 3'd2);
    cap_idx = (st == DRAIN) ? 2'd3 : cnt[1:0] - 2'd2;
  end

  always_comb begin
    mx  = CW'(max_q);
    qx  = CW'(q_cur);
    rx  = CW'($signed(req.r));
    gq  = mx - (mx >>> GAMMA_SHIFT);
    if (req.term) gq = '0;
    tgt = rx + gq;
    td  = tgt - qx;
    res = qx + (td >>> ALPHA_SHIFT);
    // Saturate when the bits above the result sign disagree with it.
    if (res[CW-1:DATA_W-1] == '0 || res[CW-1:DATA_W-1] == '1)
      res_sat = res[DATA_W-1:0];
    else if (res[CW-1])
      res_sat = {1'b1, {(DATA_W-1){1'b0}}};
    else
      res_sat = {1'b0, {(DATA_W-1){1'b1}}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req             <= '0;
      cnt             <= '0;
      q_cur           <= '0;
      max_q           <= '0;
      max_idx         <= '0;
      q_new           <= '0;
      best_action     <= '0;
      ram.ram_rd_addr <= '0;
      ram.ram_wr_addr <= '0;
      ram.ram_wr_data <= '0;
    end else begin
      if (st == IDLE && start) begin
        req.s           <= state_cur;
        req.a           <= action_cur;
        req.sn          <= state_next;
        req.r           <= reward;
`ifdef QUPD_TERMINAL_EN
        req.term        <= terminal;
`else
        req.term        <= 1'b0;
`endif
        cnt             <= '0;
        ram.ram_rd_addr <= {state_cur, action_cur};
      end
      if (st == READ) begin
        cnt <= cnt + 3'd1;
        if (cnt != 3'd4) ram.ram_rd_addr <= {req.sn, cnt[1:0]};
        if (cnt == 3'd1) q_cur <= $signed(ram.ram_rd_data);
      end
      // Strict compare keeps the lowest action index on ties.
      if (cap_nxt && (cap_idx == 2'd0 || $signed(ram.ram_rd_data) > max_q)) begin
        max_q   <= $signed(ram.ram_rd_data);
        max_idx <= cap_idx;
      end
      if (st == CALC) begin
        q_new           <= res_sat;
        best_action     <= max_idx;
        ram.ram_wr_data <= res_sat;
        ram.ram_wr_addr <= {req.s, req.a};
      end
    end
  end
endmodule

// File: tb/tb_q_update_engine.sv
// Directed bench for q_update_engine with a behavioural 64x16 registered-read RAM.
module tb_q_update_engine;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  state_cur = '0, state_next = '0;
  logic [1:0]  action_cur = '0;
  logic [15:0] reward = '0;
`ifdef QUPD_TERMINAL_EN
  logic        terminal = 1'b0;
`endif
  logic        busy, done;
  logic [15:0] q_new;
  logic [1:0]  best_action;

  q_update_engine_if bus ();

  q_update_engine dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .state_cur   (state_cur),
    .action_cur  (action_cur),
    .state_next  (state_next),
    .reward      (reward),
`ifdef QUPD_TERMINAL_EN
    .terminal    (terminal),
`endif
    .busy        (busy),
    .done        (done),
    .q_new       (q_new),
    .best_action (best_action),
    .ram         (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [64];
  logic        ld_en = 1'b0;
  logic [5:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;

  always @(posedge clk) begin
    if (bus.ram_en) bus.ram_rd_data <= mem[bus.ram_rd_addr];
    if (bus.ram_write_en) mem[bus.ram_wr_addr] <= bus.ram_wr_data;
    else if (ld_en)       mem[ld_addr] <= ld_data;
  end

  int          vecs = 0, errs = 0;
  logic [15:0] prev_q = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [5:0] a, input logic [15:0] d);
    ld_addr = a; ld_data = d; ld_en = 1'b1;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic run(input string tag, input logic [3:0] s, input logic [1:0] a,
                     input logic [3:0] sn, input logic [15:0] r,
                     input logic [15:0] exp_q, input logic [1:0] exp_b);
    int         done_cyc, writes;
    logic [5:0] addr_exp;
    state_cur = s; action_cur = a; state_next = sn; reward = r; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done_cyc = 0; writes = 0;
    for (int c = 1; c <= 8; c++) begin
      if (c <= 5) begin
        addr_exp = (c == 1) ? {s, a} : {sn, 2'(c - 2)};
        chk({tag, ".rd_addr"}, bus.ram_rd_addr, addr_exp);
      end
      if (c == 1) begin
        chk({tag, ".busy"}, busy, 1);
        chk({tag, ".q_hold"}, q_new, prev_q);
      end
      if (done) done_cyc = c;
      if (bus.ram_write_en) writes++;
      if (c == 8) begin
        chk({tag, ".wr_en"}, bus.ram_write_en, 1);
        chk({tag, ".wr_addr"}, bus.ram_wr_addr, {s, a});
        chk({tag, ".wr_data"}, bus.ram_wr_data, exp_q);
        chk({tag, ".q_new"}, q_new, exp_q);
        chk({tag, ".best"}, best_action, exp_b);
      end
      @(posedge clk); #1;
    end
    chk({tag, ".done_cyc"}, done_cyc, 8);
    chk({tag, ".writes"}, writes, 1);
    chk({tag, ".idle"}, busy, 0);
    chk({tag, ".mem"}, mem[{s, a}], exp_q);
    prev_q = exp_q;
  endtask

  initial begin
    int writes, idles;
    #2;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.ram_en", bus.ram_en, 0);
    chk("rst.wr_en", bus.ram_write_en, 0);
    chk("rst.rd_addr", bus.ram_rd_addr, 0);
    chk("rst.wr_addr", bus.ram_wr_addr, 0);
    chk("rst.wr_data", bus.ram_wr_data, 0);
    chk("rst.q_new", q_new, 0);
    chk("rst.best", best_action, 0);

    @(posedge clk); #1;
    load(6'h16, 16'h0100);
    load(6'h24, 16'h0080); load(6'h25, 16'h0200);
    load(6'h26, 16'h0200); load(6'h27, 16'hFF00);
    load(6'h0D, 16'h7F00);
    for (int i = 0; i < 4; i++) load(6'h1C + 6'(i), 16'h7FFF);
    load(6'h08, 16'h0000);
    for (int i = 0; i < 4; i++) load(6'h10 + 6'(i), 16'h0000);
    load(6'h18, 16'h0010); load(6'h19, 16'hFFF0);
    load(6'h1A, 16'h0300); load(6'h1B, 16'h0040);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Consecutive runs exercise back-to-back acceptance right after done.
    run("basic", 4'd5, 2'd2, 4'd9, 16'h0040, 16'h0140, 2'd1);
    run("sat",   4'd3, 2'd1, 4'd7, 16'h7FFF, 16'h7FFF, 2'd0);
    run("neg",   4'd2, 2'd0, 4'd4, 16'hFF00, 16'hFFC0, 2'd0);
    run("same",  4'd6, 2'd3, 4'd6, 16'h0000, 16'h00D8, 2'd2);

    start = 1'b1;
    @(posedge clk); #1;
    writes = 0; idles = 0;
    for (int c = 1; c <= 18; c++) begin
      if (bus.ram_write_en) writes++;
      if (!busy) idles++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("hold.writes", writes, 2);
    chk("hold.idles", idles, 2);

    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("abort.busy", busy, 0);
    chk("abort.ram_en", bus.ram_en, 0);
    chk("abort.wr_en", bus.ram_write_en, 0);
    chk("abort.done", done, 0);
    chk("abort.q_new", q_new, 0);
    chk("abort.best", best_action, 0);
    chk("abort.wr_data", bus.ram_wr_data, 0);
    chk("abort.rd_addr", bus.ram_rd_addr, 0);
    @(negedge clk); rst = 1'b0;
    prev_q = '0;
    writes = 0; idles = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (bus.ram_write_en) writes++;
      if (!busy) idles++;
    end
    chk("abort.writes", writes, 0);
    chk("abort.idles", idles, 10);

`ifdef QUPD_TERMINAL_EN
    load(6'h16, 16'h0100);
    terminal = 1'b1;
    run("term", 4'd5, 2'd2, 4'd9, 16'h0040, 16'h00D0, 2'd1);
    terminal = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/q_update_engine.md
Name: q_update_engine

Overview:
Q-learning write-back stage that sits directly in front of the action RAM (64 x 16-bit Q-table, address = {state[3:0], action[1:0]}, 1-cycle registered read).
- On `start`, reads Q(s,a) and the four Q(s',a') entries, finds their max, and computes Q_new = Q + alpha*(r + gamma*maxQ' - Q) with shift-based alpha/gamma and saturation.
- Writes Q_new back to the RAM.
- Also reports the greedy action for s'.

Parameters:
- DATA_W, 16, Q-value / reward width, two's-complement signed.
- ALPHA_SHIFT, 2, learning rate alpha = 2^-ALPHA_SHIFT.
- GAMMA_SHIFT, 3, discount gamma = 1 - 2^-GAMMA_SHIFT.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request an update; sampled only in IDLE.
- state_cur  input  4  current state s.
- action_cur  input  2  action taken a.
- state_next  input  4  next state s'.
- reward  input  16  signed reward r.
- busy  output  1  high from the cycle after start acceptance through the WRITE cycle.
- done  output  1  one-cycle pulse, coincident with the RAM write.
- q_new  output  16  last computed Q value; held until the next done.
- best_action  output  2  argmax over a' of Q(s',a'); held until the next done.
- ram_en  output  1  RAM read enable (equals busy).
- ram_rd_addr  output  6  RAM read address.
- ram_rd_data  input  16  RAM registered read data.
- ram_wr_addr  output  6  RAM write address.
- ram_write_en  output  1  RAM write strobe.
- ram_wr_data  output  16  RAM write data.

Behaviour:
- Reset (async): state IDLE. busy, done, ram_en, ram_write_en = 0. All addresses, ram_wr_data, q_new, best_action = 0. Reset mid-operation aborts with no write; ram_write_en drops immediately.
- FSM: IDLE -> READ -> DRAIN -> CALC -> WRITE -> IDLE.
- IDLE: on start=1 at edge E0, latch state_cur, action_cur, state_next, reward; go to READ with cnt=0. start while busy is ignored, not queued.
- READ (5 cycles, cnt 0..4):
  - cnt0: ram_rd_addr = {s,a}.
  - cnt1..4: ram_rd_addr = {s', cnt-1}.
- Capture: data for the address driven in cycle k is sampled at the end of cycle k+1. Q captured at E2; Q(s',0..3) captured at E3..E6, the last one during DRAIN.
- Max tracking: running signed max; strict greater-than replaces the current max, so ties keep the lowest action index. The first next-state value initialises the max.
- CALC (ends at E7), 18-bit signed intermediates:
  - gq = maxQ - (maxQ >>> GAMMA_SHIFT)
  - tgt = reward + gq
  - td = tgt - Q
  - res = Q + (td >>> ALPHA_SHIFT)
  - Arithmetic shifts round toward -inf. res saturates to [0x8000, 0x7FFF].
- WRITE (cycle after E7):
  - ram_write_en = 1, ram_wr_addr = {s,a}, ram_wr_data = res, done = 1.
  - q_new and best_action update at E7 and are valid while done is high.
  - Return to IDLE at E8.
- Latency: done is high exactly in the 8th cycle after the start-sampling edge. Back-to-back starts are possible, with start accepted in the cycle after done.
- s' == s: all reads complete before the write; no hazard, old values are used.
- ram_rd_addr holds its last value outside READ. ram_write_en = 0 in all states except WRITE.

Optional Feature:
- Macro QUPD_TERMINAL_EN.
- Defined: adds input port `terminal` (1 bit), latched with start. When the latched value is 1, gq is forced to 0 (target = reward). Reads, max tracking, best_action and latency are unchanged.
- Undefined: port absent; gq is always bootstrapped from maxQ'.

Test Plan:
- Address sequence: state_cur=5, action_cur=2, state_next=9 -> ram_rd_addr 0x16, 0x24, 0x25, 0x26, 0x27 on consecutive cycles; ram_wr_addr=0x16; done in the 8th cycle after start.
- Basic update: Q=0x0100, Q(s',0..3)=0x0080, 0x0200, 0x0200, 0xFF00, reward=0x0040 -> best_action=1 (tie), q_new=ram_wr_data=0x0140.
- Positive saturation: Q=0x7F00, all Q(s')=0x7FFF, reward=0x7FFF -> q_new=0x7FFF.
- Negative reward: Q=0, all Q(s')=0, reward=0xFF00 -> q_new=0xFFC0.
- Control: start held high in every cycle -> accepted only in IDLE, one write per 8-cycle window. rst asserted during READ -> no ram_write_en pulse, outputs at reset values, busy=0 immediately.
- QUPD_TERMINAL_EN: basic-update stimulus with terminal=1 -> q_new=0x00D0, best_action=1.
